sram_port_arbiter: RTL and testbench

//  Shares one synchronous single-port SRAM (1-cycle read latency) between the

---
 rtl/sram_port_arbiter.sv | 101 ++++++++++
 tb/tb_sram_port_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sram_port_arbiter.sv
// Arbitrates one single-port SRAM between instruction fetch (IF) and the MEM stage.
// MEM wins ties unless IF has lost STARVE_MAX ties in a row; responses return one cycle after grant.
module sram_port_arbiter #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = 3,
  localparam int CNT_W     = $clog2(STARVE_MAX + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_valid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              mem_req,
  input  logic [3:0]        mem_wen,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wdata,
  output logic              mem_gnt,
  output logic              mem_valid,
  output logic [DATA_W-1:0] mem_rdata,
  output logic              sram_en,
  output logic [3:0]        sram_wen,
  output logic [ADDR_W-1:0] sram_addr,
  output logic [DATA_W-1:0] sram_wdata,
  input  logic [DATA_W-1:0] sram_rdata,
  output logic [1:0]        dbg_resp_owner,
  output logic [CNT_W-1:0]  dbg_starve_cnt
);

  // Handshake: a requester holds req and its payload until it sees gnt; the access
  // is issued in the gnt cycle and completes with a one-cycle valid pulse on the next edge.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_MEM  = 2'd2
  } owner_t;

  owner_t           resp_owner, resp_owner_nxt;
  logic             resp_is_wr, resp_is_wr_nxt;
  logic [CNT_W-1:0] starve_cnt, starve_cnt_nxt;
  logic             starved;

  // Grants are blanked during reset so nothing reaches the SRAM.
  always_comb begin
    starved = (starve_cnt == CNT_W'(STARVE_MAX));
    if_gnt  = 1'b0;
    mem_gnt = 1'b0;
    if (!reset) begin
      if (mem_req && !(if_req && starved)) mem_gnt = 1'b1;
      else if (if_req)                     if_gnt  = 1'b1;
    end
  end

  always_comb begin
    sram_en    = if_gnt | mem_gnt;
    sram_wen   = mem_gnt ? mem_wen : 4'b0000;
    sram_wdata = mem_gnt ? mem_wdata : '0;
    if (mem_gnt)     sram_addr = mem_addr;
    else if (if_gnt) sram_addr = if_addr;
    else             sram_addr = '0;
  end

  // MEM only beats a waiting IF while not starved, so the counter cannot pass STARVE_MAX.
  always_comb begin
    resp_owner_nxt = OWN_NONE;
    resp_is_wr_nxt = 1'b0;
    starve_cnt_nxt = starve_cnt;
    if (mem_gnt) begin
      resp_owner_nxt = OWN_MEM;
      resp_is_wr_nxt = (mem_wen != 4'b0000);
      if (if_req && !starved) starve_cnt_nxt = starve_cnt + 1'b1;
    end else if (if_gnt) begin
      resp_owner_nxt = OWN_IF;
      starve_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      resp_owner <= OWN_NONE;
      resp_is_wr <= 1'b0;
      starve_cnt <= '0;
    end else begin
      resp_owner <= resp_owner_nxt;
      resp_is_wr <= resp_is_wr_nxt;
      starve_cnt <= starve_cnt_nxt;
    end
  end

  always_comb begin
    if_valid       = (resp_owner == OWN_IF);
    mem_valid      = (resp_owner == OWN_MEM);
    if_rdata       = if_valid ? sram_rdata : '0;
    mem_rdata      = (mem_valid && !resp_is_wr) ? sram_rdata : '0;
    dbg_resp_owner = resp_owner;
    dbg_starve_cnt = starve_cnt;
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: SRAM model returns addr ^ 0x5A5A0000 on reads
// and all-ones after writes, so stale or ungated read data is visible.
module tb_sram_port_arbiter;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int CNT_W  = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic              if_req, if_gnt, if_valid;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              mem_req, mem_gnt, mem_valid;
  logic [3:0]        mem_wen;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata, mem_rdata;
  logic              sram_en;
  logic [3:0]        sram_wen;
  logic [ADDR_W-1:0] sram_addr;
  logic [DATA_W-1:0] sram_wdata;
  logic [DATA_W-1:0] sram_rdata = '0;
  logic [1:0]        dbg_resp_owner;
  logic [CNT_W-1:0]  dbg_starve_cnt;

  int checks = 0;
  int errors = 0;
  logic [DATA_W-1:0] exp_q[$];

  sram_port_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STARVE_MAX(3)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_valid(if_valid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_valid(mem_valid), .mem_rdata(mem_rdata),
    .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
    .sram_rdata(sram_rdata), .dbg_resp_owner(dbg_resp_owner), .dbg_starve_cnt(dbg_starve_cnt)
  );

  // Clock/reset: posedge at 5,15,...; inputs driven at negedge, outputs sampled 1ns later.
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (sram_en) sram_rdata <= (sram_wen == 4'b0000) ? (sram_addr ^ 32'h5A5A_0000) : 32'hFFFF_FFFF;
  end

  task automatic test_reset;
    reset = 1'b1; if_req = 1'b0; mem_req = 1'b0; if_addr = '0;
    mem_wen = 4'b0000; mem_addr = '0; mem_wdata = '0;
    repeat (2) @(negedge clk);
    if_req = 1'b1; mem_req = 1'b1; if_addr = 32'h10; mem_addr = 32'h20;
    #1;
    checks++; if (if_gnt !== 1'b0)  begin errors++; $display("FAIL rst_if_gnt: got %0b want 0", if_gnt); end
    checks++; if (mem_gnt !== 1'b0) begin errors++; $display("FAIL rst_mem_gnt: got %0b want 0", mem_gnt); end
    checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL rst_sram_en: got %0b want 0", sram_en); end
    checks++; if (sram_addr !== 32'h0) begin errors++; $display("FAIL rst_sram_addr: got %h want 0", sram_addr); end
    checks++; if (if_valid !== 1'b0 || mem_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b/%0b want 0/0", if_valid, mem_valid); end
    checks++; if (dbg_resp_owner !== 2'd0) begin errors++; $display("FAIL rst_owner: got %0d want 0", dbg_resp_owner); end
    checks++; if (dbg_starve_cnt !== 2'd0) begin errors++; $display("FAIL rst_starve: got %0d want 0", dbg_starve_cnt); end
    @(negedge clk);
    reset = 1'b0; if_req = 1'b0; mem_req = 1'b0;
    #1;
    checks++; if (sram_en !== 1'b0) begin errors++; $display("FAIL idle_sram_en: got %0b want 0", sram_en); end
  endtask

  task automatic test_if_only;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'hBFC0_0000;
    #1;
    checks++; if (if_gnt !== 1'b1)  begin errors++; $display("FAIL if1_gnt: got %0b want 1", if_gnt); end
    checks++; if (mem_gnt !== 1'b0) begin errors++; $display("FAIL if1_mem_gnt: got %0b want 0", mem_gnt); end
    checks++; if (sram_en !== 1'b1) begin errors++; $display("FAIL if1_sram_en: got %0b want 1", sram_en); end
    checks++; if (sram_addr !== 32'hBFC0_0000) begin errors++; $display("FAIL if1_sram_addr: got %h want bfc00000", sram_addr); end
    checks++; if (sram_wen !== 4'b0000) begin errors++; $display("FAIL if1_sram_wen: got %b want 0000", sram_wen); end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL if1_valid: got %0b want 1", if_valid); end
    checks++; if (if_rdata !== 32'hE59A_0000) begin errors++; $display("FAIL if1_rdata: got %h want e59a0000", if_rdata); end
    checks++; if (mem_valid !== 1'b0) begin errors++; $display("FAIL if1_mem_valid: got %0b want 0", mem_valid); end
    @(negedge clk);
    #1;
    checks++; if (if_valid !== 1'b0 || if_rdata !== 32'h0) begin errors++; $display("FAIL if1_valid_drop: got %0b/%h want 0/0", if_valid, if_rdata); end
  endtask

  task automatic test_write_priority;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h8;
    mem_req = 1'b1; mem_wen = 4'b0011; mem_addr = 32'h100; mem_wdata = 32'hA5A5;
    #1;
    checks++; if (mem_gnt !== 1'b1 || if_gnt !== 1'b0) begin errors++; $display("FAIL wr_gnt: got mem=%0b if=%0b want 1/0", mem_gnt, if_gnt); end
    checks++; if (sram_wen !== 4'b0011) begin errors++; $display("FAIL wr_sram_wen: got %b want 0011", sram_wen); end
    checks++; if (sram_addr !== 32'h100) begin errors++; $display("FAIL wr_sram_addr: got %h want 100", sram_addr); end
    checks++; if (sram_wdata !== 32'hA5A5) begin errors++; $display("FAIL wr_sram_wdata: got %h want a5a5", sram_wdata); end
    @(negedge clk);
    mem_req = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b1) begin errors++; $display("FAIL wr_valid: got %0b want 1", mem_valid); end
    checks++; if (mem_rdata !== 32'h0) begin errors++; $display("FAIL wr_rdata: got %h want 0", mem_rdata); end
    checks++; if (dbg_starve_cnt !== 2'd1) begin errors++; $display("FAIL wr_starve: got %0d want 1", dbg_starve_cnt); end
    checks++; if (if_gnt !== 1'b1) begin errors++; $display("FAIL wr_if_follow: got %0b want 1", if_gnt); end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    checks++; if (dbg_starve_cnt !== 2'd0) begin errors++; $display("FAIL wr_starve_clr: got %0d want 0", dbg_starve_cnt); end
    checks++; if (if_rdata !== 32'h5A5A_0008) begin errors++; $display("FAIL wr_if_rdata: got %h want 5a5a0008", if_rdata); end
  endtask

  // Both held 8 cycles: expected M,M,M,I,M,M,M,I; valids trail by one cycle.
  task automatic test_starvation;
    logic exp_m, exp_i, prev_m, prev_i;
    mem_wen = 4'b0000; mem_addr = 32'h300; if_addr = 32'h400;
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      if_req = (i < 8); mem_req = (i < 8);
      #1;
      exp_m  = (i < 8) && (i % 4 != 3);
      exp_i  = (i < 8) && (i % 4 == 3);
      prev_m = (i > 0) && ((i - 1) % 4 != 3);
      prev_i = (i > 0) && ((i - 1) % 4 == 3);
      checks++; if (mem_gnt !== exp_m) begin errors++; $display("FAIL st_mem_gnt[%0d]: got %0b want %0b", i, mem_gnt, exp_m); end
      checks++; if (if_gnt !== exp_i) begin errors++; $display("FAIL st_if_gnt[%0d]: got %0b want %0b", i, if_gnt, exp_i); end
      checks++; if (mem_valid !== prev_m) begin errors++; $display("FAIL st_mem_valid[%0d]: got %0b want %0b", i, mem_valid, prev_m); end
      checks++; if (if_valid !== prev_i) begin errors++; $display("FAIL st_if_valid[%0d]: got %0b want %0b", i, if_valid, prev_i); end
      if (prev_m) begin
        checks++; if (mem_rdata !== 32'h5A5A_0300) begin errors++; $display("FAIL st_mem_rdata[%0d]: got %h want 5a5a0300", i, mem_rdata); end
      end
      if (prev_i) begin
        checks++; if (if_rdata !== 32'h5A5A_0400) begin errors++; $display("FAIL st_if_rdata[%0d]: got %h want 5a5a0400", i, if_rdata); end
      end
      if (i == 3) begin
        checks++; if (dbg_starve_cnt !== 2'd3) begin errors++; $display("FAIL st_cnt_sat: got %0d want 3", dbg_starve_cnt); end
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [DATA_W-1:0] exp_d;
    exp_q.delete();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      if_req = (k < 4); if_addr = 32'(4 * k);
      #1;
      checks++; if (if_gnt !== (k < 4)) begin errors++; $display("FAIL b2b_gnt[%0d]: got %0b want %0b", k, if_gnt, (k < 4)); end
      if (k > 0) begin
        exp_d = exp_q.pop_front();
        checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d]: got %0b want 1", k, if_valid); end
        checks++; if (if_rdata !== exp_d) begin errors++; $display("FAIL b2b_rdata[%0d]: got %h want %h", k, if_rdata, exp_d); end
      end
      if (k < 4) exp_q.push_back(32'h5A5A_0000 | 32'(4 * k));
    end
    if_req = 1'b0;
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h500; mem_req = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h1F0;
    #1;
    checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL rm_pre_gnt: got %0b want 1", mem_gnt); end
    @(negedge clk);
    mem_addr = 32'h200;
    #1;
    checks++; if (mem_gnt !== 1'b1 || sram_addr !== 32'h200) begin errors++; $display("FAIL rm_gnt: got %0b/%h want 1/200", mem_gnt, sram_addr); end
    checks++; if (dbg_starve_cnt !== 2'd1) begin errors++; $display("FAIL rm_starve_pre: got %0d want 1", dbg_starve_cnt); end
    #1 reset = 1'b1;
    #1;
    checks++; if (mem_gnt !== 1'b0 || if_gnt !== 1'b0) begin errors++; $display("FAIL rm_rst_gnt: got %0b/%0b want 0/0", mem_gnt, if_gnt); end
    checks++; if (sram_en !== 1'b0 || sram_addr !== 32'h0) begin errors++; $display("FAIL rm_rst_sram: got en=%0b addr=%h want 0/0", sram_en, sram_addr); end
    checks++; if (sram_wen !== 4'b0 || sram_wdata !== 32'h0) begin errors++; $display("FAIL rm_rst_wr: got %b/%h want 0/0", sram_wen, sram_wdata); end
    checks++; if (mem_valid !== 1'b0 || mem_rdata !== 32'h0) begin errors++; $display("FAIL rm_rst_valid: got %0b/%h want 0/0", mem_valid, mem_rdata); end
    checks++; if (dbg_starve_cnt !== 2'd0) begin errors++; $display("FAIL rm_rst_starve: got %0d want 0", dbg_starve_cnt); end
    @(negedge clk);
    reset = 1'b0; if_req = 1'b0; mem_req = 1'b0;
    #1;
    checks++; if (mem_valid !== 1'b0 || if_valid !== 1'b0) begin errors++; $display("FAIL rm_post_valid: got %0b/%0b want 0/0", mem_valid, if_valid); end
    @(negedge clk);
    #1;
    checks++; if (mem_valid !== 1'b0 || dbg_resp_owner !== 2'd0) begin errors++; $display("FAIL rm_post2: got %0b/%0d want 0/0", mem_valid, dbg_resp_owner); end
  endtask

  task automatic test_overlap;
    @(negedge clk);
    mem_req = 1'b1; mem_wen = 4'b0000; mem_addr = 32'h40;
    #1;
    checks++; if (mem_gnt !== 1'b1) begin errors++; $display("FAIL ov_mem_gnt: got %0b want 1", mem_gnt); end
    @(negedge clk);
    mem_req = 1'b0; if_req = 1'b1; if_addr = 32'h80;
    #1;
    checks++; if (mem_valid !== 1'b1 || if_gnt !== 1'b1) begin errors++; $display("FAIL ov_overlap: got valid=%0b gnt=%0b want 1/1", mem_valid, if_gnt); end
    checks++; if (mem_rdata !== 32'h5A5A_0040) begin errors++; $display("FAIL ov_mem_rdata: got %h want 5a5a0040", mem_rdata); end
    checks++; if (sram_addr !== 32'h80) begin errors++; $display("FAIL ov_sram_addr: got %h want 80", sram_addr); end
    @(negedge clk);
    if_req = 1'b0;
    #1;
    checks++; if (if_valid !== 1'b1 || mem_valid !== 1'b0) begin errors++; $display("FAIL ov_if_valid: got %0b/%0b want 1/0", if_valid, mem_valid); end
    checks++; if (if_rdata !== 32'h5A5A_0080) begin errors++; $display("FAIL ov_if_rdata: got %h want 5a5a0080", if_rdata); end
  endtask

  initial begin
    test_reset();
    test_if_only();
    test_write_priority();
    test_starvation();
    test_back_to_back();
    test_reset_mid();
    test_overlap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout want completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
